write_buffer: RTL and testbench
===============================

Name: write_buffer

Overview:
- Sits between the data cache's memory port and main memory.
- Absorbs the cache's write-through stores in a small FIFO and drains them to memory in order.
- Services the cache's line-refill reads one word per beat, so store traffic does not serialise behind the memory latency.
- Read/write ordering is enforced here, so memory never returns stale data to a refill.

Parameters:
- DEPTH, 4, number of buffered store entries (power of 2, 2..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width (one word per entry/beat)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- c_read  in  1  cache read (refill beat) request; held until c_ready
- c_write  in  1  cache write-through request (merged word)
- c_addr  in  ADDR_W  cache request address (word aligned)
- c_wdata  in  DATA_W  cache store data
- c_rdata  out  DATA_W  read data to cache, valid when c_ready && c_read
- c_ready  out  1  request accepted (write) / data returned (read) this cycle
- m_read  out  1  memory read request
- m_write  out  1  memory write request
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data
- m_ready  in  1  memory completes current request this cycle
- wb_full  out  1  all DEPTH entries occupied; pipeline stalls stores on this
- wb_empty  out  1  no entries pending

Behaviour:
- Reset (async): FIFO pointers and count cleared; state IDLE.
  - Outputs on reset: m_read=m_write=0, m_addr=m_wdata=0, c_ready=0, c_rdata=0, wb_full=0, wb_empty=1.
  - Reset mid-transaction abandons it; buffered stores are discarded.
- Memory handshake: m_read/m_write, m_addr and m_wdata are registered outputs, held stable until the cycle m_ready=1. That cycle completes the request; at most one request is outstanding.
- Write accept:
  - When c_write && !wb_full, c_ready=1 combinationally and the entry {c_addr, c_wdata} is enqueued at the clock edge.
  - When full, c_ready=0 and nothing is enqueued, even if a drain completes that same cycle (no same-cycle full pass-through).
  - Writes are accepted in any state.
- c_read && c_write together: the write is serviced and the read is held (c_ready refers to the write).
- Same-address stores stay distinct entries: no coalescing, strict FIFO drain order.
- FSM states: IDLE, DRAIN, READ.
  - IDLE, FIFO non-empty and no eligible read: load the head entry into m_addr/m_wdata, assert m_write, go to DRAIN.
  - IDLE, c_read and FIFO empty: latch c_addr, assert m_read, go to READ.
  - DRAIN, m_ready: pop the head, deassert m_write, go to IDLE. Back-to-back drains therefore cost 1 idle cycle each.
  - READ, m_ready: c_rdata=m_rdata and c_ready=1 in the same cycle (combinational pass-through); deassert m_read; go to IDLE.
  - Any illegal state encoding goes to IDLE.
- Read ordering (default build): a pending c_read waits until the FIFO is empty (drain-before-read). Latency per read beat = drain time + 1 cycle + memory latency.
- Count/flags: wb_full = (count==DEPTH); wb_empty = (count==0).
  - Same-cycle enqueue and dequeue (not full) leaves count unchanged.
  - Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: WB_READ_BYPASS_EN.
- Defined: reads have priority over drain.
  - In IDLE, c_read is compared against all valid entries.
  - On a match, the youngest matching entry's data is returned with c_ready=1 in that cycle; no memory access, state stays IDLE.
  - On no match, the read goes to READ immediately, ahead of pending stores.
  - A drain already in DRAIN completes first.
- Undefined: drain-before-read as above; no address comparators are built.

Decomposition:
- Shared package wb_pkg:
  - wb_state_t enum {IDLE, DRAIN, READ}
  - wb_entry_t struct {addr, data}
  - WB_DEPTH_DEFAULT constant
- Sub-module wb_fifo: DEPTH-entry circular buffer with push/pop, head output, count, full/empty, plus a flattened entry view for the bypass compare.
- FSM and handshake logic stay in write_buffer.

Test Plan:
- Reset mid-DRAIN, with 2 entries queued and m_write=1 → m_write drops during reset; wb_empty=1 and no m_write after release.
- 4 writes 0x100..0x10C with data 0xA0..0xA3, m_ready tied 1 → each c_ready=1 on its cycle; m_write order 0x100, 0x104, 0x108, 0x10C with matching data; wb_empty=1 afterwards.
- Fill to DEPTH with m_ready=0, then a 5th write → c_ready=0 and wb_full=1. Raise m_ready for 1 cycle → 0x100 drains and wb_full=0. The 5th write is accepted the following cycle.
- Write 0x200=0xDEADBEEF, then c_read 0x200 with memory holding 0x0, default build → m_write 0x200 precedes m_read 0x200; returned data is memory's value after the write.
- WB_READ_BYPASS_EN, m_ready=0, entries 0x300=0x11 then 0x300=0x22, c_read 0x300 → c_ready=1 the same cycle with c_rdata=0x22; no m_read issued.
- 4-beat refill 0x400..0x40C, memory latency 3 cycles → each beat's c_ready coincides with m_ready; c_rdata equals the memory word for each address.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the write buffer.
//   wb_state_t       : controller states (IDLE, DRAIN, READ)
//   wb_entry_t       : one buffered store {addr, data} at the default widths
//   WB_DEPTH_DEFAULT : default number of store entries
package wb_pkg;

    localparam int unsigned WB_DEPTH_DEFAULT = 4;
    localparam int unsigned WB_ADDR_W        = 32;
    localparam int unsigned WB_DATA_W        = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        READ  = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular store buffer for write_buffer.
//   clk, reset    : clock, asynchronous active-high reset (pointers/count only)
//   push, push_data : enqueue one entry (ignored when full)
//   pop           : dequeue the head entry (ignored when empty)
//   head          : oldest entry
//   count, full, empty : occupancy
//   entries_flat, valid_mask : age-ordered view (index 0 = oldest), only
//                   present when WB_READ_BYPASS_EN is defined
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH_DEFAULT,
    parameter int unsigned W     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
`ifdef WB_READ_BYPASS_EN
    ,
    output logic [DEPTH*W-1:0]     entries_flat,
    output logic [DEPTH-1:0]       valid_mask
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_en, pop_en;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = push_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop_en  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

`ifdef WB_READ_BYPASS_EN
    always_comb begin
        entries_flat = '0;
        valid_mask   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entries_flat[i*W +: W] = mem_q[PW'(rd_ptr_q + PW'(i))];
            valid_mask[i]          = (CW'(i) < count_q);
        end
    end
`endif

endmodule

// File: rtl/write_buffer.sv
// Write buffer between the data cache memory port and main memory.
// Buffers write-through stores in a FIFO and drains them in order; services
// refill reads one word per beat. Build option WB_READ_BYPASS_EN gives reads
// priority over draining and forwards the youngest matching buffered store;
// without it a read waits until every buffered store has drained.
//   clk, reset        : clock, asynchronous active-high reset
//   c_read, c_write, c_addr, c_wdata : cache request
//   c_rdata, c_ready  : cache response (write accept / read data)
//   m_read, m_write, m_addr, m_wdata : registered memory request
//   m_rdata, m_ready  : memory response
//   wb_full, wb_empty : buffer occupancy flags
module write_buffer
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH  = WB_DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_read,
    input  logic              c_write,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ready,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              wb_full,
    output logic              wb_empty
);

    localparam int unsigned EW = ADDR_W + DATA_W;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    wb_state_t         state_q, state_d;
    logic              m_read_q, m_read_d;
    logic              m_write_q, m_write_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;

    logic [EW-1:0]     fifo_head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic              read_req, read_done, byp_ret;

`ifdef WB_READ_BYPASS_EN
    logic [DEPTH*EW-1:0] fifo_entries;
    logic [DEPTH-1:0]    fifo_valid;
    logic                byp_hit;
    logic [DATA_W-1:0]   byp_data;
`endif

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_data    ({c_addr, c_wdata}),
        .pop          (pop),
        .head         (fifo_head),
        .count        (fifo_count),
        .full         (fifo_full),
        .empty        (fifo_empty)
`ifdef WB_READ_BYPASS_EN
        ,
        .entries_flat (fifo_entries),
        .valid_mask   (fifo_valid)
`endif
    );

    // Full blocks the write outright, even if a drain frees a slot this cycle.
    assign push     = c_write && !fifo_full;
    // A simultaneous write wins; the read is held until the write is gone.
    assign read_req = c_read && !c_write;

    assign wb_full  = (fifo_count == CW'(DEPTH));
    assign wb_empty = (fifo_count == '0);

`ifdef WB_READ_BYPASS_EN
    // Scan oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i] && (fifo_entries[i*EW+DATA_W +: ADDR_W] == c_addr)) begin
                byp_hit  = 1'b1;
                byp_data = fifo_entries[i*EW +: DATA_W];
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        m_read_d  = m_read_q;
        m_write_d = m_write_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        pop       = 1'b0;
        read_done = 1'b0;
        byp_ret   = 1'b0;
        unique case (state_q)
            IDLE: begin
`ifdef WB_READ_BYPASS_EN
                if (read_req && byp_hit) begin
                    byp_ret = 1'b1;
                end else if (read_req) begin
                    state_d  = READ;
                    m_read_d = 1'b1;
                    m_addr_d = c_addr;
                end else if (!fifo_empty) begin
                    state_d   = DRAIN;
                    m_write_d = 1'b1;
                    m_addr_d  = fifo_head[EW-1:DATA_W];
                    m_wdata_d = fifo_head[DATA_W-1:0];
                end
`else
                if (!fifo_empty) begin
                    state_d   = DRAIN;
                    m_write_d = 1'b1;
                    m_addr_d  = fifo_head[EW-1:DATA_W];
                    m_wdata_d = fifo_head[DATA_W-1:0];
                end else if (read_req) begin
                    state_d  = READ;
                    m_read_d = 1'b1;
                    m_addr_d = c_addr;
                end
`endif
            end
            DRAIN: begin
                if (m_ready) begin
                    pop       = 1'b1;
                    m_write_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            READ: begin
                if (m_ready) begin
                    read_done = 1'b1;
                    m_read_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                m_read_d  = 1'b0;
                m_write_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        c_ready = push || read_done;
        c_rdata = read_done ? m_rdata : '0;
`ifdef WB_READ_BYPASS_EN
        if (byp_ret) begin
            c_ready = 1'b1;
            c_rdata = byp_data;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            m_read_q  <= m_read_d;
            m_write_q <= m_write_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    assign m_read  = m_read_q;
    assign m_write = m_write_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_write_buffer.sv
module tb_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_read, c_write;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        c_ready;
    logic        m_read, m_write;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_ready;
    logic        wb_full, wb_empty;

    write_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .c_read   (c_read),
        .c_write  (c_write),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_rdata  (c_rdata),
        .c_ready  (c_ready),
        .m_read   (m_read),
        .m_write  (m_write),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .wb_full  (wb_full),
        .wb_empty (wb_empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending stores in order, plus memory contents.
    wb_pkg::wb_entry_t mq[$];
    logic [31:0]       phys [logic [31:0]];
    bit                mon_en    = 1'b0;
    bit                mem_stall = 1'b0;
    int                mem_lat   = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return phys.exists(a) ? phys[a] : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic bit has_match(input logic [31:0] a);
        foreach (mq[i]) if (mq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    // Architectural value: youngest pending store, else memory.
    function automatic logic [31:0] exp_read(input logic [31:0] a);
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].addr == a) return mq[i].data;
        return mem_rd(a);
    endfunction

    // Memory responder: m_ready after mem_lat waiting cycles.
    initial begin
        int wait_cnt = 0;
        m_ready = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                m_ready  = 1'b0;
                wait_cnt = 0;
            end else if ((m_read || m_write) && !mem_stall) begin
                if (wait_cnt >= mem_lat) begin
                    m_ready  = 1'b1;
                    m_rdata  = m_read ? mem_rd(m_addr) : 32'h0;
                    wait_cnt = 0;
                end else begin
                    m_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                m_ready = 1'b0;
            end
        end
    end

    // Per-cycle monitor against the model.
    bit          prev_pend = 1'b0;
    logic        prev_rd, prev_wr;
    logic [31:0] prev_addr, prev_wdata;

    always @(negedge clk) begin
        int  n;
        bit  exp_rdy;
        if (reset) begin
            prev_pend = 1'b0;
        end else if (mon_en) begin
            n = mq.size();
            check_eq("wb_empty", wb_empty, n == 0);
            check_eq("wb_full", wb_full, n == DEPTH);
            check_eq("one_req", m_read & m_write, 1'b0);
            if (m_read) check_eq("mread_req", c_read, 1'b1);
            if (prev_pend) begin
                check_eq("hold_rd", m_read, prev_rd);
                check_eq("hold_wr", m_write, prev_wr);
                check_eq("hold_addr", m_addr, prev_addr);
                if (prev_wr) check_eq("hold_wdata", m_wdata, prev_wdata);
            end
            if (c_write) begin
                check_eq("wr_ready", c_ready, n < DEPTH);
            end else if (c_read) begin
                exp_rdy = m_read && m_ready;
`ifdef WB_READ_BYPASS_EN
                if (!m_read && !m_write && has_match(c_addr)) exp_rdy = 1'b1;
`else
                if (m_read) check_eq("rd_order", n, 0);
`endif
                check_eq("rd_ready", c_ready, exp_rdy);
                if (exp_rdy) check_eq("rd_data", c_rdata, exp_read(c_addr));
                if (m_read && m_ready) check_eq("rd_addr", m_addr, c_addr);
            end else begin
                check_eq("idle_ready", c_ready, 1'b0);
            end
            if (m_write && m_ready) begin
                if (n == 0) begin
                    check_eq("drain_spurious", m_write, 1'b0);
                end else begin
                    check_eq("drain_addr", m_addr, mq[0].addr);
                    check_eq("drain_data", m_wdata, mq[0].data);
                    phys[m_addr] = m_wdata;
                    void'(mq.pop_front());
                end
            end
            if (c_write && n < DEPTH) mq.push_back('{addr: c_addr, data: c_wdata});
            prev_pend  = (m_read || m_write) && !m_ready;
            prev_rd    = m_read;
            prev_wr    = m_write;
            prev_addr  = m_addr;
            prev_wdata = m_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bit got = 1'b0;
        int k   = 0;
        c_write = 1'b1;
        c_addr  = a;
        c_wdata = d;
        while (!got && k < 300) begin
            @(negedge clk);
            got = c_ready;
            tick();
            k++;
        end
        if (!got) check_eq("wr_timeout", got, 1'b1);
        c_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bit got = 1'b0;
        int k   = 0;
        d      = '0;
        c_read = 1'b1;
        c_addr = a;
        while (!got && k < 500) begin
            @(negedge clk);
            got = c_ready;
            d   = c_rdata;
            tick();
            k++;
        end
        if (!got) check_eq("rd_timeout", got, 1'b1);
        c_read = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int k = 0;
        @(negedge clk);
        while (!wb_empty && k < 300) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, wb_empty, 1'b1);
        tick();
    endtask

    // Stall release pulse: memory completes exactly one request.
    task automatic pulse_release(input int delay);
        repeat (delay) @(posedge clk);
        #1 mem_stall = 1'b0;
        @(posedge clk);
        #1 mem_stall = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        reset   = 1'b1;
        c_read  = 1'b0;
        c_write = 1'b0;
        c_addr  = '0;
        c_wdata = '0;
        @(negedge clk);
        check_eq("rst_m_read", m_read, 1'b0);
        check_eq("rst_m_write", m_write, 1'b0);
        check_eq("rst_m_addr", m_addr, 32'h0);
        check_eq("rst_m_wdata", m_wdata, 32'h0);
        check_eq("rst_c_ready", c_ready, 1'b0);
        check_eq("rst_c_rdata", c_rdata, 32'h0);
        check_eq("rst_full", wb_full, 1'b0);
        check_eq("rst_empty", wb_empty, 1'b1);
        tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        // Reset in the middle of a drain discards everything.
        mem_stall = 1'b1;
        wr(32'h600, 32'h66);
        wr(32'h604, 32'h67);
        begin
            int k = 0;
            while (!m_write && k < 20) begin tick(); k++; end
            check_eq("pre_rst_mwrite", m_write, 1'b1);
        end
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check_eq("rst_async_mwrite", m_write, 1'b0);
        check_eq("rst_async_empty", wb_empty, 1'b1);
        mq.delete();
        tick();
        tick();
        reset     = 1'b0;
        mem_stall = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_eq("no_mwrite_after_rst", m_write, 1'b0);
        end
        tick();

        // Back-to-back stores with memory always ready.
        mem_lat = 0;
        for (int i = 0; i < 4; i++) wr(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        wait_empty("drain_seq_empty");

        // Fill, blocked fifth write, one drain, then acceptance.
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) wr(32'h100 + 32'(4 * i), 32'hB0 + 32'(i));
        c_write = 1'b1;
        c_addr  = 32'h110;
        c_wdata = 32'hB4;
        @(negedge clk);
        check_eq("full_flag", wb_full, 1'b1);
        check_eq("full_no_accept", c_ready, 1'b0);
        pulse_release(1);
        @(negedge clk);
        check_eq("after_drain_not_full", wb_full, 1'b0);
        check_eq("fifth_accept", c_ready, 1'b1);
        tick();
        c_write   = 1'b0;
        mem_stall = 1'b0;
        wait_empty("full_test_empty");

        // Store then read of the same address.
        phys[32'h200] = 32'h0;
        mem_lat = 1;
        wr(32'h200, 32'hDEAD_BEEF);
        rd(32'h200, d);
        check_eq("raw_data", d, 32'hDEAD_BEEF);
        wait_empty("raw_empty");

        // Same-address stores behind a stalled drain; read must see the youngest.
        mem_lat   = 0;
        mem_stall = 1'b1;
        wr(32'h2F0, 32'h77);
        wr(32'h300, 32'h11);
        wr(32'h300, 32'h22);
`ifdef WB_READ_BYPASS_EN
        fork
            pulse_release(2);
        join_none
`else
        mem_stall = 1'b0;
`endif
        rd(32'h300, d);
        check_eq("youngest_data", d, 32'h22);
        mem_stall = 1'b0;
        wait_empty("youngest_empty");

        // Four-beat refill with 3-cycle memory latency.
        mem_lat = 3;
        for (int i = 0; i < 4; i++) phys[32'h400 + 32'(4 * i)] = 32'hC0DE_0000 + 32'(i);
        for (int i = 0; i < 4; i++) begin
            rd(32'h400 + 32'(4 * i), d);
            check_eq("refill_data", d, 32'hC0DE_0000 + 32'(i));
        end

        // Randomized mix of stores, reads and idle cycles.
        for (int op = 0; op < 400; op++) begin
            int unsigned r = $urandom_range(0, 9);
            logic [31:0] a = 32'h500 + 32'(4 * $urandom_range(0, 7));
            if (op % 50 == 0) mem_lat = int'($urandom_range(0, 3));
            if (r < 5) wr(a, $urandom);
            else if (r < 8) rd(a, d);
            else repeat ($urandom_range(1, 3)) tick();
        end
        wait_empty("random_empty");
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
